// File: rtl/xgmii_rx_measure.sv
// XGMII receive measurement engine: frames 64-bit XGMII words, validates
// IPv4 test frames, and reports per-interval rate/throughput plus the
// latency and source address of the most recent valid frame.

// Per-lane control-character decode.
module xgmii_rx_lane (
  input  logic [7:0] lane_d,
  input  logic       lane_c,
  output logic       is_term,
  output logic       is_err
);
  assign is_term = lane_c && (lane_d == 8'hFD);
  assign is_err  = lane_c && (lane_d == 8'hFE);
endmodule

module xgmii_rx_measure #(
  parameter int SEC_CYCLES    = 156250000,
  parameter int MIN_FRAME_LEN = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [31:0] global_counter,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip,
  output logic        rx_frame_ok,
  output logic [15:0] rx_err_count
);
  localparam int NUM_LANES = 8;
  localparam int MAX_WORDS = 1600 / 8;
  localparam logic [31:0] SEC_RELOAD = 32'(SEC_CYCLES - 1);

  typedef enum logic {IDLE, BODY} state_t;

  // Fields captured while a frame streams in.
  typedef struct packed {
    logic [15:0] eth;
    logic [31:0] ip;
    logic [31:0] ts;
    logic [31:0] rx_ts;
  } frame_info_t;

  state_t      state, state_nxt;
  frame_info_t fi;
  logic [7:0]  widx;          // index of the word now on the bus, start word = 0
  logic [31:0] timer;
  logic [31:0] pps_cnt, byte_cnt;

  logic [NUM_LANES-1:0][7:0] lane_d;
  logic [NUM_LANES-1:0]      lane_term, lane_err;

  assign lane_d = xgmii_rxd;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    xgmii_rx_lane u_lane (
      .lane_d  (lane_d[g]),
      .lane_c  (xgmii_rxc[g]),
      .is_term (lane_term[g]),
      .is_err  (lane_err[g])
    );
  end

  logic [2:0]  first_k;
  logic        has_ctrl, term_hit, in_body, is_start, abort, end_ok, len_ok;
  logic        frame_valid, frame_err, sec_tick;
  logic [15:0] frame_len;
  logic [31:0] lat_diff;
  logic [23:0] lat_sat;
  logic [32:0] byte_sum;

  assign sec_tick = (timer == 32'd0);
  assign in_body  = (state == BODY);
  assign is_start = (xgmii_rxc == 8'h01) && (lane_d[0] == 8'hFB) && (lane_d[7] == 8'hD5);

  // Word decode: the lowest control lane decides terminate versus abort,
  // which guarantees every lane below the terminate is data.
  always_comb begin
    first_k = 3'd0;
    for (int k = NUM_LANES - 1; k >= 0; k--)
      if (xgmii_rxc[k]) first_k = 3'(k);
    has_ctrl    = |xgmii_rxc;
    term_hit    = has_ctrl && lane_term[first_k];
    abort       = in_body && ((|lane_err) || (has_ctrl && !term_hit) || (widx > 8'(MAX_WORDS)));
    end_ok      = in_body && term_hit && !abort;
    frame_len   = {5'd0, widx - 8'd1, 3'd0} + {13'd0, first_k};
    len_ok      = frame_len >= 16'(MIN_FRAME_LEN);
    frame_valid = end_ok && len_ok && (fi.eth == 16'h0800);
    frame_err   = abort || (end_ok && !len_ok);
    lat_diff    = fi.rx_ts - fi.ts;
    lat_sat     = (|lat_diff[31:24]) ? 24'hFFFFFF : lat_diff[23:0];
    byte_sum    = {1'b0, byte_cnt} + {17'd0, frame_len};
  end

  // Next-state: enter BODY on a lane-0 start, leave on terminate or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_start) state_nxt = BODY;
      BODY:    if (abort || term_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Interval timer: counts down and reloads, sec_tick marks the zero cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    timer <= SEC_RELOAD;
    else if (sec_tick) timer <= SEC_RELOAD;
    else               timer <= timer - 32'd1;
  end

  // Field capture: arrival time on start, header fields by word index.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fi   <= '0;
      widx <= '0;
    end else if (!in_body && is_start) begin
      fi.rx_ts <= global_counter;
      fi.eth   <= '0;
      widx     <= 8'd1;
    end else if (in_body) begin
      widx <= widx + 8'd1;
      case (widx)
        8'd2:    fi.eth <= {lane_d[4], lane_d[5]};
        8'd4:    fi.ip  <= {lane_d[2], lane_d[3], lane_d[4], lane_d[5]};
        8'd6:    fi.ts  <= {lane_d[2], lane_d[3], lane_d[4], lane_d[5]};
        default: ;
      endcase
    end
  end

  // Running counters, interval snapshot and per-frame results; a frame ending
  // on the tick cycle seeds the new interval instead of the snapshot.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pps_cnt       <= '0;
      byte_cnt      <= '0;
      rx_pps        <= '0;
      rx_throughput <= '0;
      rx_latency    <= '0;
      rx_ipv4_ip    <= '0;
      rx_frame_ok   <= 1'b0;
      rx_err_count  <= '0;
    end else begin
      rx_frame_ok <= frame_valid;
      if (sec_tick) begin
        rx_pps        <= pps_cnt;
        rx_throughput <= byte_cnt;
        pps_cnt       <= frame_valid ? 32'd1 : 32'd0;
        byte_cnt      <= frame_valid ? {16'd0, frame_len} : 32'd0;
      end else if (frame_valid) begin
        pps_cnt  <= (pps_cnt == 32'hFFFFFFFF) ? pps_cnt : pps_cnt + 32'd1;
        byte_cnt <= byte_sum[32] ? 32'hFFFFFFFF : byte_sum[31:0];
      end
      if (frame_valid) begin
        rx_ipv4_ip <= fi.ip;
        rx_latency <= lat_sat;
      end
      if (frame_err && (rx_err_count != 16'hFFFF))
        rx_err_count <= rx_err_count + 16'd1;
    end
  end
endmodule
